circle_encoder: RTL and testbench
=================================

CIRCLE_ENCODER -- requirements
Module: circle_encoder

Interface
REQ-001 Parameter: N, default 8, signed coordinate width; range field width is N+1.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high; ports are named clk and rst.
REQ-003 Ports (clock and reset first):
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  request pulse, sampled only in IDLE.
- pt_input  in  2N  target point {x[2N-1:N], y[N-1:0]}, signed.
- b_anchor  in  2N  anchor B {xB, yB}, signed.
- c_anchor  in  2N  anchor C {xC, yC}, signed.
- g_output  out  3N+1  {xB[3N:2N+1], yB[2N:N+1], rB[N:0]}.
- e_output  out  3N+1  {xC, yC, rC}, same packing.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the outputs update.
- sat  out  2  sat[0] = rB clipped, sat[1] = rC clipped; valid with done.

Function
REQ-004 The block SHALL compute r = floor(sqrt((x-xA)^2 + (y-yA)^2)) for A = B, then A = C.
REQ-005 Widths: differences are signed N+1 bits; squares are unsigned 2N+2 bits; sums are unsigned 2N+3 bits, zero-extended to 2N+4 for the root.
REQ-006 Each root SHALL be an exact integer floor over N+2 result bits; no rounding.
REQ-007 A root above 2^N-1 SHALL saturate to 2^N-1 and set the matching sat bit; otherwise the sat bit is 0.
REQ-008 The r fields are non-negative, so their MSB is always 0.
REQ-009 FSM states: IDLE, LOAD, ROOT_B, ROOT_C, OUT.
- IDLE -> LOAD on start.
- LOAD (1 cycle): latch all inputs and form the B sum.
- ROOT_B (N+2 cycles) -> ROOT_C (N+2 cycles).
- OUT (1 cycle): register outputs, pulse done -> IDLE.
REQ-010 Latency: done SHALL be high exactly 2N+6 clock edges after the edge that samples start.
REQ-011 Both anchors SHALL share one root engine, used serially.
REQ-012 start while busy SHALL be ignored and SHALL NOT corrupt the operation in flight.
REQ-013 Input changes after LOAD SHALL have no effect on the current result.
REQ-014 g_output, e_output and sat SHALL hold their last values between done pulses.
REQ-015 Back-to-back use: start asserted in the cycle done is high SHALL be ignored. The earliest accepted start is the cycle after done.
REQ-016 Point equal to an anchor SHALL give r = 0 and sat bit 0.

Reset
REQ-017 While rst is high, the block SHALL:
- set state to IDLE;
- drive busy=0, done=0, sat=0, g_output=0, e_output=0;
- clear all root-engine registers.
REQ-018 rst mid-operation SHALL abort the operation with no done pulse. A start in the first cycle after rst deasserts SHALL be accepted.

Structure
REQ-019 The shared package SHALL hold:
- the FSM state encoding;
- field offset constants for the {x,y,r} packing, shared with the intersection consumer;
- the saturation limit function of N.
REQ-020 One sub-module, isqrt_iter: a bit-serial restoring integer square root with:
- a load input and a start-of-root strobe;
- one result bit per cycle;
- a done strobe.
It is instantiated once.

Verification (N=8)
REQ-021 pt=(3,4), B=(0,0), C=(-3,0) -> rB=5, rC=7 (sqrt 52); g_output={0,0,5}; sat=00; done 22 edges after start.
REQ-022 pt=(-5,-12), B=(0,0), C=(-5,-12) -> rB=13, rC=0, sat=00.
REQ-023 pt=(127,127), B=(-128,-128), C=(127,-128) -> rB=255 with sat[0]=1; rC=255 exact with sat[1]=0.
REQ-024 start re-pulsed at cycles 3 and 10 of an operation, with pt changed -> single done at cycle 22; results match the original inputs.
REQ-025 rst asserted at cycle 12 of an operation -> no done; all outputs 0. New start on the first post-reset cycle -> correct result 22 edges later.
REQ-026 Random regression, 10^4 vectors -> rB and rC equal floor(sqrt(d2)) clipped to 255; sat matches the clip; latency constant.

Source files
------------

// File: rtl/circle_encoder_pkg.sv
// Shared definitions for the circle encoder and its consumers.
package circle_encoder_pkg;

    // Controller state encoding
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_ROOT_B = 3'd2,
        ST_ROOT_C = 3'd3,
        ST_OUT    = 3'd4
    } state_t;

    // {x, y, r} packing of an encoded anchor: r is N+1 bits at the bottom,
    // then y (N bits), then x (N bits) at the top.
    localparam int R_LSB = 0;

    function automatic int unsigned y_lsb(input int unsigned n);
        return n + 1;
    endfunction

    function automatic int unsigned x_lsb(input int unsigned n);
        return 2 * n + 1;
    endfunction

    // Largest range value representable in an N-bit magnitude
    function automatic int unsigned sat_limit(input int unsigned n);
        return (32'd1 << n) - 32'd1;
    endfunction

endpackage

// File: rtl/circle_encoder_isqrt_iter.sv
// Bit-serial restoring integer square root, one result bit per clock.
// load captures the radicand, start clears the partial root and begins
// R iterations; done is asserted during the cycle whose edge produces the
// final bit, and root_next carries the finished root in that cycle.
// A new load/start may coincide with that final edge.
module isqrt_iter
    import circle_encoder_pkg::*;
#(
    parameter int R = 10,
    parameter int W = 2 * R
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         start,
    input  logic [W-1:0] radicand,
    output logic [R-1:0] root_next,
    output logic         done
);

    localparam int CW = (R > 1) ? $clog2(R) : 1;

    logic [W-1:0]  op;
    logic [R:0]    rem;
    logic [R-1:0]  root;
    logic [CW-1:0] cnt;
    logic          active;

    logic [R+2:0]  rem_shift;
    logic [R+2:0]  trial;
    logic [R+2:0]  diff;
    logic          ge;
    logic [R:0]    rem_next;

    // One restoring step: bring down two radicand bits, try 4*root+1
    always_comb begin
        rem_shift = {rem, op[W-1 -: 2]};
        trial     = {1'b0, root, 2'b01};
        diff      = rem_shift - trial;
        ge        = (rem_shift >= trial);
        rem_next  = (R + 1)'(ge ? diff : rem_shift);
        root_next = {root[R-2:0], ge};
        done      = active && (cnt == '0);
    end

    // Iteration registers; cnt is a down-counter to terminal count zero
    always_ff @(posedge clk) begin
        if (rst) begin
            op     <= '0;
            rem    <= '0;
            root   <= '0;
            cnt    <= '0;
            active <= 1'b0;
        end else begin
            if (load) begin
                op <= radicand;
            end else if (active) begin
                op <= op << 2;
            end

            if (start) begin
                rem    <= '0;
                root   <= '0;
                cnt    <= CW'(R - 1);
                active <= 1'b1;
            end else if (active) begin
                rem  <= rem_next;
                root <= root_next;
                if (cnt == '0) begin
                    active <= 1'b0;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/circle_encoder.sv
// Encodes a point as its integer distances to two anchors B and C.
// Both distances go through one shared serial square-root engine.
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | waiting for start (ignored while done is still high)
// ST_LOAD    | latch inputs, feed B distance^2 to the root engine
// ST_ROOT_B  | N+2 root iterations for B; last edge feeds C to engine
// ST_ROOT_C  | N+2 root iterations for C
// ST_OUT     | clip, register outputs, pulse done
module circle_encoder
    import circle_encoder_pkg::*;
#(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [2*N-1:0] pt_input,
    input  logic [2*N-1:0] b_anchor,
    input  logic [2*N-1:0] c_anchor,
    output logic [3*N:0]   g_output,
    output logic [3*N:0]   e_output,
    output logic           busy,
    output logic           done,
    output logic [1:0]     sat
);

    localparam int RB    = N + 2;
    localparam int W     = 2 * N + 4;
    localparam int X_LSB = int'(x_lsb(N));
    localparam int Y_LSB = int'(y_lsb(N));
    localparam logic [N+1:0] LIM = (N + 2)'(sat_limit(N));

    state_t         state;
    logic [2*N-1:0] pt_reg;
    logic [2*N-1:0] b_reg;
    logic [2*N-1:0] c_reg;
    logic [N+1:0]   rb_raw;
    logic [N+1:0]   rc_raw;

    logic [2*N-1:0] p_sel;
    logic [2*N-1:0] a_sel;
    logic signed [N:0]     dx;
    logic signed [N:0]     dy;
    logic signed [2*N+1:0] dx_ext;
    logic signed [2*N+1:0] dy_ext;
    logic [2*N+1:0] sq_x;
    logic [2*N+1:0] sq_y;
    logic [2*N+2:0] sum;
    logic [W-1:0]   radicand;

    logic           eng_kick;
    logic           eng_done;
    logic [RB-1:0]  root_next;

    function automatic logic [N:0] clip_r(input logic [N+1:0] r);
        return (r > LIM) ? LIM[N:0] : r[N:0];
    endfunction

    // Squared distance: B comes straight off the ports in LOAD, C from the latched copy
    always_comb begin
        if (state == ST_LOAD) begin
            p_sel = pt_input;
            a_sel = b_anchor;
        end else begin
            p_sel = pt_reg;
            a_sel = c_reg;
        end
        dx       = $signed({p_sel[2*N-1], p_sel[2*N-1:N]}) - $signed({a_sel[2*N-1], a_sel[2*N-1:N]});
        dy       = $signed({p_sel[N-1], p_sel[N-1:0]}) - $signed({a_sel[N-1], a_sel[N-1:0]});
        dx_ext   = {{(N+1){dx[N]}}, dx};
        dy_ext   = {{(N+1){dy[N]}}, dy};
        sq_x     = $unsigned(dx_ext * dx_ext);
        sq_y     = $unsigned(dy_ext * dy_ext);
        sum      = {1'b0, sq_x} + {1'b0, sq_y};
        radicand = {1'b0, sum};
        eng_kick = (state == ST_LOAD) || ((state == ST_ROOT_B) && eng_done);
    end

    isqrt_iter #(
        .R (RB),
        .W (W)
    ) u_isqrt (
        .clk       (clk),
        .rst       (rst),
        .load      (eng_kick),
        .start     (eng_kick),
        .radicand  (radicand),
        .root_next (root_next),
        .done      (eng_done)
    );

    // Sequencing FSM with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            sat      <= 2'b00;
            g_output <= '0;
            e_output <= '0;
            pt_reg   <= '0;
            b_reg    <= '0;
            c_reg    <= '0;
            rb_raw   <= '0;
            rc_raw   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start && !done) begin
                        state <= ST_LOAD;
                        busy  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    pt_reg <= pt_input;
                    b_reg  <= b_anchor;
                    c_reg  <= c_anchor;
                    state  <= ST_ROOT_B;
                end
                ST_ROOT_B: begin
                    if (eng_done) begin
                        rb_raw <= root_next;
                        state  <= ST_ROOT_C;
                    end
                end
                ST_ROOT_C: begin
                    if (eng_done) begin
                        rc_raw <= root_next;
                        state  <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    g_output[X_LSB +: N]     <= b_reg[2*N-1:N];
                    g_output[Y_LSB +: N]     <= b_reg[N-1:0];
                    g_output[R_LSB +: N + 1] <= clip_r(rb_raw);
                    e_output[X_LSB +: N]     <= c_reg[2*N-1:N];
                    e_output[Y_LSB +: N]     <= c_reg[N-1:0];
                    e_output[R_LSB +: N + 1] <= clip_r(rc_raw);
                    sat   <= {(rc_raw > LIM), (rb_raw > LIM)};
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_circle_encoder.sv
// Directed and small randomized checks of circle_encoder with N = 8.
module tb_circle_encoder;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] pt_input;
    logic [15:0] b_anchor;
    logic [15:0] c_anchor;
    logic [24:0] g_output;
    logic [24:0] e_output;
    logic        busy;
    logic        done;
    logic [1:0]  sat;

    int checks;
    int failures;

    circle_encoder #(.N(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .pt_input (pt_input),
        .b_anchor (b_anchor),
        .c_anchor (c_anchor),
        .g_output (g_output),
        .e_output (e_output),
        .busy     (busy),
        .done     (done),
        .sat      (sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    function automatic int isqrt_model(input int v);
        int r;
        r = 0;
        while ((r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    function automatic logic [24:0] pack_exp(input logic [7:0] x, input logic [7:0] y, input int r);
        int rc;
        rc = (r > 255) ? 255 : r;
        return {x, y, 9'(rc)};
    endfunction

    task automatic set_inputs(input logic [7:0] px, input logic [7:0] py,
                              input logic [7:0] bx, input logic [7:0] by,
                              input logic [7:0] cx, input logic [7:0] cy);
        pt_input = {px, py};
        b_anchor = {bx, by};
        c_anchor = {cx, cy};
    endtask

    // Drive start for exactly one sampling edge; returns #1 after that edge
    task automatic do_start();
        @(negedge clk);
        if (done) @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts edges after the start edge until done; -1 when it never comes
    task automatic wait_done(output int lat);
        lat = -1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        set_inputs(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6);
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (sat !== 2'b00) begin failures++; $display("FAIL reset_sat got=%b exp=00", sat); end
        checks++; if (g_output !== 25'd0) begin failures++; $display("FAIL reset_g got=%h exp=0", g_output); end
        checks++; if (e_output !== 25'd0) begin failures++; $display("FAIL reset_e got=%h exp=0", e_output); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int lat;
        logic [24:0] g_exp, e_exp;
        g_exp = {8'h00, 8'h00, 9'd5};
        e_exp = {8'hFD, 8'h00, 9'd7};
        set_inputs(8'd3, 8'd4, 8'd0, 8'd0, 8'hFD, 8'd0);
        do_start();
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy_start got=%b exp=1", busy); end
        wait_done(lat);
        checks++; if (lat != 22) begin failures++; $display("FAIL basic_latency got=%0d exp=22", lat); end
        checks++; if (g_output !== g_exp) begin failures++; $display("FAIL basic_g got=%h exp=%h", g_output, g_exp); end
        checks++; if (e_output !== e_exp) begin failures++; $display("FAIL basic_e got=%h exp=%h", e_output, e_exp); end
        checks++; if (sat !== 2'b00) begin failures++; $display("FAIL basic_sat got=%b exp=00", sat); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_done got=%b exp=0", busy); end
        set_inputs(8'd50, 8'd60, 8'd70, 8'd80, 8'd90, 8'd100);
        repeat (5) @(posedge clk);
        #1;
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL hold_done got=%b exp=0", done); end
        checks++; if (g_output !== g_exp) begin failures++; $display("FAIL hold_g got=%h exp=%h", g_output, g_exp); end
        checks++; if (e_output !== e_exp) begin failures++; $display("FAIL hold_e got=%h exp=%h", e_output, e_exp); end
    endtask

    task automatic test_restart();
        int first, ndone;
        logic [24:0] g_exp, e_exp;
        g_exp = {8'h00, 8'h00, 9'd5};
        e_exp = {8'hFD, 8'h00, 9'd7};
        first = -1;
        ndone = 0;
        set_inputs(8'd3, 8'd4, 8'd0, 8'd0, 8'hFD, 8'd0);
        do_start();
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 3 || k == 10) begin
                start    = 1'b1;
                pt_input = {8'd100, 8'h9C};
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            if (done) begin
                ndone++;
                if (first < 0) first = k;
            end
        end
        start = 1'b0;
        checks++; if (first != 22) begin failures++; $display("FAIL restart_latency got=%0d exp=22", first); end
        checks++; if (ndone != 1) begin failures++; $display("FAIL restart_done_count got=%0d exp=1", ndone); end
        checks++; if (g_output !== g_exp) begin failures++; $display("FAIL restart_g got=%h exp=%h", g_output, g_exp); end
        checks++; if (e_output !== e_exp) begin failures++; $display("FAIL restart_e got=%h exp=%h", e_output, e_exp); end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [24:0] g1, e1, g2, e2;
        g1 = {8'h00, 8'h00, 9'd13};
        e1 = {8'hFB, 8'hF4, 9'd0};
        g2 = {8'h80, 8'h80, 9'd255};
        e2 = {8'h7F, 8'h80, 9'd255};
        set_inputs(8'hFB, 8'hF4, 8'd0, 8'd0, 8'hFB, 8'hF4);
        do_start();
        wait_done(lat);
        checks++; if (lat != 22) begin failures++; $display("FAIL equal_latency got=%0d exp=22", lat); end
        checks++; if (g_output !== g1) begin failures++; $display("FAIL equal_g got=%h exp=%h", g_output, g1); end
        checks++; if (e_output !== e1) begin failures++; $display("FAIL equal_e got=%h exp=%h", e_output, e1); end
        checks++; if (sat !== 2'b00) begin failures++; $display("FAIL equal_sat got=%b exp=00", sat); end
        // start raised while done is still high: first edge ignored, next accepted
        set_inputs(8'h7F, 8'h7F, 8'h80, 8'h80, 8'h7F, 8'h80);
        start = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_ignored got=%b exp=0", busy); end
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_accepted got=%b exp=1", busy); end
        wait_done(lat);
        checks++; if (lat != 22) begin failures++; $display("FAIL sat_latency got=%0d exp=22", lat); end
        checks++; if (g_output !== g2) begin failures++; $display("FAIL sat_g got=%h exp=%h", g_output, g2); end
        checks++; if (e_output !== e2) begin failures++; $display("FAIL sat_e got=%h exp=%h", e_output, e2); end
        checks++; if (sat !== 2'b01) begin failures++; $display("FAIL sat_bits got=%b exp=01", sat); end
    endtask

    task automatic test_reset_abort();
        int early, lat;
        logic [24:0] g_exp, e_exp;
        g_exp = {8'hF6, 8'h05, 9'd32};
        e_exp = {8'h00, 8'h00, 9'd22};
        early = 0;
        set_inputs(8'd3, 8'd4, 8'd0, 8'd0, 8'hFD, 8'd0);
        do_start();
        for (int k = 1; k <= 11; k++) begin
            @(posedge clk);
            #1;
            if (done) early++;
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (early != 0) begin failures++; $display("FAIL abort_early_done got=%0d exp=0", early); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL abort_done got=%b exp=0", done); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
        checks++; if (g_output !== 25'd0) begin failures++; $display("FAIL abort_g got=%h exp=0", g_output); end
        checks++; if (e_output !== 25'd0) begin failures++; $display("FAIL abort_e got=%h exp=0", e_output); end
        checks++; if (sat !== 2'b00) begin failures++; $display("FAIL abort_sat got=%b exp=00", sat); end
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b1;
        set_inputs(8'd10, 8'hEC, 8'hF6, 8'd5, 8'd0, 8'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL post_reset_accept got=%b exp=1", busy); end
        wait_done(lat);
        checks++; if (lat != 22) begin failures++; $display("FAIL post_reset_latency got=%0d exp=22", lat); end
        checks++; if (g_output !== g_exp) begin failures++; $display("FAIL post_reset_g got=%h exp=%h", g_output, g_exp); end
        checks++; if (e_output !== e_exp) begin failures++; $display("FAIL post_reset_e got=%h exp=%h", e_output, e_exp); end
    endtask

    task automatic test_random();
        int lat, dx, dy, rb, rc;
        logic [15:0] p, b, c;
        logic [24:0] g_exp, e_exp;
        logic [1:0] s_exp;
        for (int i = 0; i < 150; i++) begin
            p = 16'($urandom);
            b = 16'($urandom);
            c = 16'($urandom);
            dx = int'($signed(p[15:8])) - int'($signed(b[15:8]));
            dy = int'($signed(p[7:0])) - int'($signed(b[7:0]));
            rb = isqrt_model(dx * dx + dy * dy);
            dx = int'($signed(p[15:8])) - int'($signed(c[15:8]));
            dy = int'($signed(p[7:0])) - int'($signed(c[7:0]));
            rc = isqrt_model(dx * dx + dy * dy);
            g_exp = pack_exp(b[15:8], b[7:0], rb);
            e_exp = pack_exp(c[15:8], c[7:0], rc);
            s_exp = {(rc > 255), (rb > 255)};
            set_inputs(p[15:8], p[7:0], b[15:8], b[7:0], c[15:8], c[7:0]);
            do_start();
            wait_done(lat);
            checks++; if (lat != 22) begin failures++; $display("FAIL rand%0d_latency got=%0d exp=22", i, lat); end
            checks++; if (g_output !== g_exp) begin failures++; $display("FAIL rand%0d_g got=%h exp=%h", i, g_output, g_exp); end
            checks++; if (e_output !== e_exp) begin failures++; $display("FAIL rand%0d_e got=%h exp=%h", i, e_output, e_exp); end
            checks++; if (sat !== s_exp) begin failures++; $display("FAIL rand%0d_sat got=%b exp=%b", i, sat, s_exp); end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        start    = 1'b0;
        pt_input = '0;
        b_anchor = '0;
        c_anchor = '0;
        test_reset();
        test_basic();
        test_restart();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
